regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of each register in bits.
REQ-002 SHALL have parameter DEPTH, default 32: number of registers, 2..256; AW = clog2(DEPTH).
REQ-003 SHALL have parameter NUM_RD, default 2: number of read ports, 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1: when 1, register 0 always reads 0 and ignores writes.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port rd_addr, input, NUM_RD*AW: packed read addresses, port k at slice [k*AW +: AW].
REQ-008 SHALL have port rd_data, output, NUM_RD*WIDTH: packed read data, port k at slice [k*WIDTH +: WIDTH].
REQ-009 SHALL have port wr_en, input, 2: per-write-port enables.
REQ-010 SHALL have ports wr_addr0/wr_addr1, input, AW each: write addresses.
REQ-011 SHALL have ports wr_data0/wr_data1, input, WIDTH each: write data.
REQ-012 SHALL have port clr_req, input, 1: single-cycle pulse requesting a soft clear of all registers.
REQ-013 SHALL have port ready, output, 1: high when the file accepts writes and returns stored data.

Function
REQ-014 SHALL implement a two-state FSM, CLEAR and RUN; ready = (state == RUN), registered.
REQ-015 SHALL, in CLEAR, write 0 to entry clr_cnt each cycle and increment clr_cnt; when clr_cnt == DEPTH-1, go to RUN and reset clr_cnt to 0.
REQ-016 SHALL, in CLEAR, ignore wr_en and drive every rd_data slice to 0.
REQ-017 SHALL, in RUN, go to CLEAR with clr_cnt = 0 on the edge where clr_req = 1; writes in that same cycle are discarded.
REQ-018 SHALL ignore clr_req while in CLEAR; the clear is not restarted.
REQ-019 SHALL, in RUN, write wr_dataN to entry wr_addrN on the edge where wr_en[N] = 1.
REQ-020 SHALL, when both ports write the same address in one cycle, store wr_data1 (port 1 wins).
REQ-021 SHALL discard writes to address 0 when ZERO_REG = 1, and writes to any address >= DEPTH.
REQ-022 SHALL make reads combinational with zero-cycle latency.
REQ-023 SHALL bypass on reads: if an enabled write port in RUN targets rd_addr and the write is not discarded, rd_data returns that write data, port 1 taking priority over port 0.
REQ-024 SHALL return 0 for a read of address 0 when ZERO_REG = 1, and for any address >= DEPTH.

Reset
REQ-025 SHALL, while rst = 1, set state = CLEAR, clr_cnt = 0 and ready = 0; rst overrides clr_req and writes.
REQ-026 SHALL have ready rise on the DEPTH-th rising edge after rst deasserts, and not earlier; rst mid-clear restarts the count from 0.
REQ-027 SHALL hold all register contents at 0 once ready first rises; register storage itself is not reset directly.

Structure
REQ-028 SHALL place the state enum (CLEAR, RUN) and the AW-width helper function in shared package regfile_pkg.
REQ-029 SHALL split the CLEAR/RUN FSM and clr_cnt into sub-module regfile_clear_fsm, which outputs clr_en, clr_idx and ready.
REQ-030 SHALL keep the storage array, write arbitration and bypass mux in regfile_mp.

Verification
REQ-031 SHALL cover: rst for 2 cycles then released with DEPTH = 32 -> ready = 0 for 31 edges, 1 on edge 32; all reads return 0.
REQ-032 SHALL cover: write 0xDEADBEEF to reg 5 via port 0 while reading reg 5 -> rd_data = 0xDEADBEEF the same cycle (bypass) and after the edge.
REQ-033 SHALL cover: both ports write reg 7, port 0 with 0x1111 and port 1 with 0x2222 -> reg 7 reads 0x2222.
REQ-034 SHALL cover: write 0xFFFFFFFF to reg 0 with ZERO_REG = 1 -> reg 0 reads 0 in the same cycle and afterwards.
REQ-035 SHALL cover: clr_req pulse with a simultaneous write to reg 3 -> write discarded; ready = 0 for 32 cycles, then all regs read 0.
REQ-036 SHALL cover: rst asserted while clr_cnt = 10 -> clr_cnt = 0 and ready rises on edge 32 after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and address-width helper for the register file
package regfile_pkg;

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

    function automatic int aw_f(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm: sequences a soft clear across every entry, then holds RUN until clr_req
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = aw_f(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_en,
    output logic [AW-1:0] clr_idx,
    output logic          ready
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // walk clr_cnt through every entry in CLEAR; a clr_req in RUN restarts the sweep at 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(DEPTH - 1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else if (clr_req) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end
    end

    // reset forces CLEAR so contents are zeroed before ready ever rises
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clr_en  = (state_q == CLEAR);
    assign clr_idx = cnt_q;
    assign ready   = (state_q == RUN);

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with write bypass and soft clear
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int NUM_RD   = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = aw_f(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    input  logic [1:0]              wr_en,
    input  logic [AW-1:0]           wr_addr0,
    input  logic [AW-1:0]           wr_addr1,
    input  logic [WIDTH-1:0]        wr_data0,
    input  logic [WIDTH-1:0]        wr_data1,
    input  logic                    clr_req,
    output logic                    ready
);

    logic             clr_en;
    logic [AW-1:0]    clr_idx;
    logic [1:0]       we;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    regfile_clear_fsm #(.DEPTH(DEPTH)) u_fsm (
        .clk    (clk),
        .rst    (rst),
        .clr_req(clr_req),
        .clr_en (clr_en),
        .clr_idx(clr_idx),
        .ready  (ready)
    );

    // a write lands only in RUN, outside reset, not under a clear request, and to a real entry
    assign we[0] = ready && !rst && !clr_req && wr_en[0] && addr_ok(wr_addr0);
    assign we[1] = ready && !rst && !clr_req && wr_en[1] && addr_ok(wr_addr1);

    // clear sweep zeroes one entry per cycle; otherwise port 1 is applied last so it wins
    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_idx] = '0;
        end else begin
            if (we[0]) mem_d[wr_addr0] = wr_data0;
            if (we[1]) mem_d[wr_addr1] = wr_data1;
        end
    end

    // storage is not reset; the clear sweep after reset zeroes it
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rd_addr[k*AW +: AW];
        assign rd_data[k*WIDTH +: WIDTH] =
            (!ready || !addr_ok(ra))   ? '0       :
            (we[1] && wr_addr1 == ra)  ? wr_data1 :
            (we[0] && wr_addr0 == ra)  ? wr_data0 :
                                         mem_q[ra];
    end

endmodule
